// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_if: byte-in / packed-BCD-out bus between the binary source and the converter.
// The master drives in_valid/bin; the slave (converter) drives out_valid/out_bcd.
interface bin_to_bcd_if;
   logic        in_valid;
   logic [7:0]  bin;
   logic        out_valid;
   logic [11:0] out_bcd;

   modport master (
      output in_valid,
      output bin,
      input  out_valid,
      input  out_bcd
   );

   modport slave (
      input  in_valid,
      input  bin,
      output out_valid,
      output out_bcd
   );
endinterface

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: registered 8-bit binary to 3-digit packed BCD converter, one conversion per clock.
// Define BIN2BCD_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module bin_to_bcd (
   input logic         clk,
   input logic         rst_n,
   bin_to_bcd_if.slave bcd_io
);

   // Double-dabble over a {bcd[11:0], bin[7:0]} scratch: correct nibbles >= 5, then shift.
   function automatic logic [11:0] dabble(input logic [7:0] b);
      logic [19:0] s;
      s = {12'h000, b};
      for (int i = 0; i < 8; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (s[8+4*d +: 4] >= 4'd5) begin
               s[8+4*d +: 4] = s[8+4*d +: 4] + 4'd3;
            end
         end
         s = s << 1;
      end
      return s[19:8];
   endfunction

   logic       cv_valid;
   logic [7:0] cv_bin;

`ifdef BIN2BCD_IN_REG_EN
   logic       in_valid_q;
   logic [7:0] bin_q;

   // bin is captured only with in_valid so an undriven bus never reaches the converter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_valid_q <= 1'b0;
         bin_q      <= 8'h00;
      end else begin
         in_valid_q <= bcd_io.in_valid;
         if (bcd_io.in_valid) begin
            bin_q <= bcd_io.bin;
         end
      end
   end

   assign cv_valid = in_valid_q;
   assign cv_bin   = bin_q;
`else
   assign cv_valid = bcd_io.in_valid;
   assign cv_bin   = bcd_io.bin;
`endif

   logic [11:0] bcd_d, bcd_q;
   logic        valid_q;

   always_comb begin
      bcd_d = bcd_q;
      if (cv_valid) begin
         bcd_d = dabble(cv_bin);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q   <= 12'h000;
         valid_q <= 1'b0;
      end else begin
         bcd_q   <= bcd_d;
         valid_q <= cv_valid;
      end
   end

   assign bcd_io.out_bcd   = bcd_q;
   assign bcd_io.out_valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: directed and shuffled-sweep checks of bin_to_bcd against a divide/modulo model.
// Honours BIN2BCD_IN_REG_EN for the expected latency.
module tb_bin_to_bcd;

`ifdef BIN2BCD_IN_REG_EN
   localparam int Latency = 2;
`else
   localparam int Latency = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;

   bin_to_bcd_if bus ();

   bin_to_bcd dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bcd_io (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        pipe_v[$];
   logic [7:0]  pipe_b[$];
   logic [11:0] exp_bcd;
   logic        exp_valid;

   function automatic logic [11:0] bin2bcd(input int b);
      return 12'((b / 100) * 256 + ((b / 10) % 10) * 16 + (b % 10));
   endfunction

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_bcd   = 12'h000;
      exp_valid = 1'b0;
      pipe_v.delete();
      pipe_b.delete();
      for (int i = 0; i < Latency - 1; i++) begin
         pipe_v.push_back(1'b0);
         pipe_b.push_back(8'h00);
      end
   endtask

   // Called at a falling edge: drive, clock once, compare at the next falling edge.
   task automatic cycle(input logic v, input logic [7:0] b);
      logic       ev;
      logic [7:0] eb;
      bus.in_valid = v;
      bus.bin      = b;
      pipe_v.push_back(v);
      pipe_b.push_back(b);
      @(posedge clk);
      @(negedge clk);
      ev = pipe_v.pop_front();
      eb = pipe_b.pop_front();
      if (ev) exp_bcd = bin2bcd(int'(eb));
      exp_valid = ev;
      check("model_bcd", bus.out_bcd, exp_bcd);
      check("model_vld", {11'h000, bus.out_valid}, {11'h000, exp_valid});
   endtask

   task automatic idle();
      cycle(1'b0, 8'hxx);
   endtask

   logic [7:0]  bnd_in  [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
   logic [11:0] bnd_exp [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
   logic [7:0]  str_in  [3] = '{8'd1, 8'd128, 8'd200};
   logic [11:0] str_exp [3] = '{12'h001, 12'h128, 12'h200};
   int          vals    [256];

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.bin      = 8'h00;
      model_reset();
      #1;
      check("reset_bcd", bus.out_bcd, 12'h000);
      check("reset_vld", {11'h000, bus.out_valid}, 12'h000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Boundary values, each read after the pipeline latency.
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, bnd_in[i]);
         for (int k = 0; k < Latency - 1; k++) idle();
         check($sformatf("bnd_%0d", bnd_in[i]), bus.out_bcd, bnd_exp[i]);
         check("bnd_vld", {11'h000, bus.out_valid}, 12'h001);
      end

      // Back-to-back stream must come out back-to-back with out_valid held high.
      for (int i = 0; i < 3 + Latency - 1; i++) begin
         if (i < 3) cycle(1'b1, str_in[i]);
         else idle();
         if (i >= Latency - 1) begin
            check("stream_bcd", bus.out_bcd, str_exp[i-Latency+1]);
            check("stream_vld", {11'h000, bus.out_valid}, 12'h001);
         end
      end

      // Hold with an undriven bin while in_valid is low.
      cycle(1'b1, 8'd47);
      for (int i = 0; i < Latency - 1 + 3; i++) begin
         idle();
         if (i >= Latency - 1) begin
            check("hold_bcd", bus.out_bcd, 12'h047);
            check("hold_vld", {11'h000, bus.out_valid}, 12'h000);
         end
      end

      // Asynchronous reset asserted mid-cycle while showing 255.
      cycle(1'b1, 8'd255);
      for (int k = 0; k < Latency - 1; k++) idle();
      check("pre_rst_bcd", bus.out_bcd, 12'h255);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bcd", bus.out_bcd, 12'h000);
      check("async_rst_vld", {11'h000, bus.out_valid}, 12'h000);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // Full sweep in shuffled order against the model.
      for (int i = 0; i < 256; i++) vals[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int t;
         j       = int'($urandom_range(i, 0));
         t       = vals[i];
         vals[i] = vals[j];
         vals[j] = t;
      end
      for (int i = 0; i < 256; i++) cycle(1'b1, 8'(vals[i]));
      for (int k = 0; k < Latency + 1; k++) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
